// File: rtl/processor_defs.sv
// Shared opcode constants, instruction field positions and decode helpers
// used by the fetch/decode side of the 5-stage pipeline.
package processor_defs;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam int FIELD_W    = 5;
  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_LSB     = 17;
  localparam int RT_LSB     = 12;
  localparam int ALU_OP_LSB = 2;
  localparam int TARGET_W   = 27;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // j and jal carry an absolute target and are taken in fetch.
  function automatic logic is_early_jump(input logic [31:0] insn);
    logic hit_s;
    case (insn[OPCODE_LSB +: FIELD_W])
      OP_J, OP_JAL: hit_s = 1'b1;
      default:      hit_s = 1'b0;
    endcase
    return hit_s;
  endfunction

endpackage

// File: rtl/stage_fetch_fd_latch.sv
// F/D pipeline register: reset beats flush, flush beats stall, stall beats load.
// A flush keeps the old pc so the bubble still carries a sensible address.
module fd_latch
  import processor_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] load_insn,
  input  logic [31:0] load_pc,
  input  logic        load_early_jump,
  output logic        fd_valid,
  output logic [31:0] fd_insn,
  output logic [31:0] fd_pc,
  output logic        fd_early_jump
);

  logic        valid_r;
  logic [31:0] insn_r;
  logic [31:0] pc_r;
  logic        early_jump_r;

  // F/D register update with reset/flush/stall/load priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r      <= 1'b0;
      insn_r       <= NOP_WORD;
      pc_r         <= 32'd0;
      early_jump_r <= 1'b0;
    end else if (flush) begin
      valid_r      <= 1'b0;
      insn_r       <= NOP_WORD;
      early_jump_r <= 1'b0;
    end else if (stall) begin
      valid_r      <= valid_r;
      insn_r       <= insn_r;
      pc_r         <= pc_r;
      early_jump_r <= early_jump_r;
    end else begin
      valid_r      <= 1'b1;
      insn_r       <= load_insn;
      pc_r         <= load_pc;
      early_jump_r <= load_early_jump;
    end
  end

  assign fd_valid      = valid_r;
  assign fd_insn       = insn_r;
  assign fd_pc         = pc_r;
  assign fd_early_jump = early_jump_r;

endmodule

// File: rtl/stage_fetch.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address and
// feeds the F/D register whose contents are sliced into decode fields.
module stage_fetch
  import processor_defs::*;
#(
  parameter int IMEM_AW = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic               fd_valid,
  output logic [31:0]        fd_insn,
  output logic [31:0]        fd_pc,
  output logic [31:0]        fd_pc_plus1,
  output logic               fd_early_jump,
  output logic [4:0]         opcode,
  output logic [4:0]         rd,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         ALU_op
);

  logic [31:0] pc_r;
  logic [31:0] next_pc_s;
  logic        early_jump_s;

  assign early_jump_s = is_early_jump(imem_data);

  // Next fetch address; the ROM is synchronous so this is its read address.
  always_comb begin
    next_pc_s = pc_r + 32'd1;
    if (reset) begin
      next_pc_s = 32'd0;
    end else if (redirect_valid) begin
      next_pc_s = redirect_pc;
    end else if (stall) begin
      next_pc_s = pc_r;
    end else if (early_jump_s) begin
      next_pc_s = {5'b00000, imem_data[TARGET_W-1:0]};
    end else begin
      next_pc_s = pc_r + 32'd1;
    end
  end

  // pc_r always names the word currently presented on imem_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= 32'd0;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  assign imem_addr = next_pc_s[IMEM_AW-1:0];

  fd_latch u_fd_latch (
    .clock           (clock),
    .reset           (reset),
    .flush           (redirect_valid),
    .stall           (stall),
    .load_insn       (imem_data),
    .load_pc         (pc_r),
    .load_early_jump (early_jump_s),
    .fd_valid        (fd_valid),
    .fd_insn         (fd_insn),
    .fd_pc           (fd_pc),
    .fd_early_jump   (fd_early_jump)
  );

  assign fd_pc_plus1 = fd_pc + 32'd1;
  assign opcode      = fd_insn[OPCODE_LSB +: FIELD_W];
  assign rd          = fd_insn[RD_LSB +: FIELD_W];
  assign rs          = fd_insn[RS_LSB +: FIELD_W];
  assign rt          = fd_insn[RT_LSB +: FIELD_W];
  assign ALU_op      = fd_insn[ALU_OP_LSB +: FIELD_W];

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch with a bench-owned synchronous ROM model.
module tb_stage_fetch;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic        fd_valid;
  logic [31:0] fd_insn;
  logic [31:0] fd_pc;
  logic [31:0] fd_pc_plus1;
  logic        fd_early_jump;
  logic [4:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  ALU_op;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];

  stage_fetch #(.IMEM_AW(12)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fd_valid       (fd_valid),
    .fd_insn        (fd_insn),
    .fd_pc          (fd_pc),
    .fd_pc_plus1    (fd_pc_plus1),
    .fd_early_jump  (fd_early_jump),
    .opcode         (opcode),
    .rd             (rd),
    .rs             (rs),
    .rt             (rt),
    .ALU_op         (ALU_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) imem_data <= mem[imem_addr];

  // Default ROM contents: addi opcode with the address in the low bits.
  function automatic logic [31:0] word(input int i);
    return {5'b00101, 27'(i)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_fd(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] insn, input logic ej);
    chk({tag, ".valid"}, {31'd0, fd_valid}, {31'd0, v});
    chk({tag, ".pc"}, fd_pc, pc);
    chk({tag, ".insn"}, fd_insn, insn);
    chk({tag, ".ej"}, {31'd0, fd_early_jump}, {31'd0, ej});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = word(i);
    mem[3] = 32'hABCD_1234;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;

    // Reset state
    tick();
    tick();
    chk_fd("reset", 1'b0, 32'd0, 32'd0, 1'b0);
    chk("reset.imem_addr", {20'd0, imem_addr}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset.imem_addr", {20'd0, imem_addr}, 32'd1);

    // Sequential fetch 0..3
    tick(); chk_fd("seq0", 1'b1, 32'd0, word(0), 1'b0);
    chk("seq0.pc_plus1", fd_pc_plus1, 32'd1);
    tick(); chk_fd("seq1", 1'b1, 32'd1, word(1), 1'b0);
    tick(); chk_fd("seq2", 1'b1, 32'd2, word(2), 1'b0);
    tick(); chk_fd("seq3", 1'b1, 32'd3, 32'hABCD_1234, 1'b0);
    chk("seq3.opcode", {27'd0, opcode}, 32'd21);
    chk("seq3.rd", {27'd0, rd}, 32'd15);
    chk("seq3.rs", {27'd0, rs}, 32'd6);
    chk("seq3.rt", {27'd0, rt}, 32'd17);
    chk("seq3.alu_op", {27'd0, ALU_op}, 32'd13);
    tick(); chk_fd("seq4", 1'b1, 32'd4, word(4), 1'b0);

    // Redirect to 100 while pc_q = 5
    redirect_valid = 1'b1;
    redirect_pc = 32'd100;
    #1;
    chk("redir.imem_addr", {20'd0, imem_addr}, 32'd100);
    tick(); chk_fd("redir.bubble", 1'b0, 32'd4, 32'd0, 1'b0);
    chk("redir.bubble.opcode", {27'd0, opcode}, 32'd0);
    redirect_valid = 1'b0;
    tick(); chk_fd("redir.target", 1'b1, 32'd100, word(100), 1'b0);

    // Move to pc 7, then stall three cycles
    redirect_valid = 1'b1;
    redirect_pc = 32'd7;
    tick(); chk_fd("to7.bubble", 1'b0, 32'd100, 32'd0, 1'b0);
    redirect_valid = 1'b0;
    tick(); chk_fd("to7", 1'b1, 32'd7, word(7), 1'b0);
    stall = 1'b1;
    #1;
    chk("stall.imem_addr", {20'd0, imem_addr}, 32'd8);
    for (int k = 0; k < 3; k++) begin
      tick(); chk_fd("stall.hold", 1'b1, 32'd7, word(7), 1'b0);
    end
    stall = 1'b0;
    tick(); chk_fd("stall.resume8", 1'b1, 32'd8, word(8), 1'b0);
    tick(); chk_fd("stall.resume9", 1'b1, 32'd9, word(9), 1'b0);

    // Stall and redirect together: flush wins
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd40;
    #1;
    chk("both.imem_addr", {20'd0, imem_addr}, 32'd40);
    tick(); chk_fd("both.bubble", 1'b0, 32'd9, 32'd0, 1'b0);
    stall = 1'b0;
    redirect_valid = 1'b0;
    tick(); chk_fd("both.target", 1'b1, 32'd40, word(40), 1'b0);

    // Reach pc 57, then reset mid-run
    redirect_valid = 1'b1;
    redirect_pc = 32'd55;
    tick();
    redirect_valid = 1'b0;
    tick(); chk_fd("run55", 1'b1, 32'd55, word(55), 1'b0);
    tick(); chk_fd("run56", 1'b1, 32'd56, word(56), 1'b0);
    reset = 1'b1;
    #1;
    chk("midreset.imem_addr", {20'd0, imem_addr}, 32'd0);
    tick(); chk_fd("midreset", 1'b0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    mem[2]  = {5'b00001, 27'd20};
    mem[21] = {5'b00011, 27'd50};
    tick(); chk_fd("restart0", 1'b1, 32'd0, word(0), 1'b0);

    // Early j at 2 and jal at 21, no bubbles
    tick(); chk_fd("ej.pc1", 1'b1, 32'd1, word(1), 1'b0);
    chk("ej.imem_addr", {20'd0, imem_addr}, 32'd20);
    tick(); chk_fd("ej.j", 1'b1, 32'd2, 32'h0800_0014, 1'b1);
    tick(); chk_fd("ej.target20", 1'b1, 32'd20, word(20), 1'b0);
    tick(); chk_fd("ej.jal", 1'b1, 32'd21, 32'h1800_0032, 1'b1);
    chk("ej.jal.pc_plus1", fd_pc_plus1, 32'd22);
    chk("ej.jal.opcode", {27'd0, opcode}, 32'd3);
    tick(); chk_fd("ej.target50", 1'b1, 32'd50, word(50), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
